// File: rtl/dsa_pkg.sv
// Shared constants and types for the output-image streamer.
package dsa_pkg;

    localparam int unsigned AW_DEF         = 12;
    localparam int unsigned PIX_W_DEF      = 8;
    localparam int unsigned PREFETCH_DEPTH = 2;
    localparam int unsigned PF_CNT_W       = $clog2(PREFETCH_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } strm_state_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head so head is a plain flop.
module pix_fifo2
    import dsa_pkg::*;
#(
    parameter int unsigned W = PIX_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [W-1:0]        push_data,
    input  logic                pop,
    output logic [W-1:0]        head,
    output logic                empty,
    output logic [PF_CNT_W-1:0] count
);

    logic [W-1:0]        r_d0;
    logic [W-1:0]        r_d1;
    logic [PF_CNT_W-1:0] r_cnt;

    // Shift-style storage update; push+pop keeps occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_cnt == '0) r_d0 <= push_data;
                    else             r_d1 <= push_data;
                    r_cnt <= r_cnt + PF_CNT_W'(1);
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_cnt <= r_cnt - PF_CNT_W'(1);
                end
                2'b11: begin
                    if (r_cnt == PF_CNT_W'(1)) begin
                        r_d0 <= push_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = r_d0;
    assign empty = (r_cnt == '0);
    assign count = r_cnt;

endmodule

// File: rtl/img_out_streamer.sv
// Reads a frame of pixels from a 1-cycle-latency BRAM and emits it as a
// valid/ready stream with an end-of-frame marker.
module img_out_streamer
    import dsa_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             start,
    input  logic [AW:0]      num_pix,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_raddr,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_last
);

    localparam int unsigned   NW    = AW + 1;
    localparam logic [NW-1:0] MAX_N = NW'(1) << AW;

    strm_state_t         r_state;
    strm_state_t         w_state_next;
    logic [NW-1:0]       r_n;
    logic [NW-1:0]       r_iss;
    logic [NW-1:0]       r_beat;
    logic [AW-1:0]       r_raddr;
    logic                r_inflight;
    logic                r_busy;
    logic                r_done;

    logic [NW-1:0]       w_n_clamped;
    logic                w_start_ok;
    logic                w_fifo_empty;
    logic [PF_CNT_W-1:0] w_fifo_count;
    logic                w_valid;
    logic                w_pop;
    logic [PF_CNT_W-1:0] w_used;
    logic                w_issue;
    logic                w_last_beat;

    assign w_n_clamped = (num_pix > MAX_N) ? MAX_N : num_pix;
    assign w_start_ok  = start && (r_state == IDLE);
    assign w_valid     = !w_fifo_empty;
    assign w_pop       = w_valid && m_ready;
    // A slot freed by this cycle's pop can be refilled by a read issued now.
    assign w_used      = PF_CNT_W'(r_inflight) + w_fifo_count - PF_CNT_W'(w_pop);
    assign w_issue     = (r_state == RUN) && (r_iss < r_n) &&
                         (w_used < PF_CNT_W'(PREFETCH_DEPTH));
    assign w_last_beat = (r_beat == r_n - NW'(1));

    // Prefetch buffer between the BRAM read port and the stream output.
    pix_fifo2 #(
        .W (PIX_W)
    ) u_fifo (
        .clk       (clk_50),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (mem_rdata),
        .pop       (w_pop),
        .head      (m_data),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // State register.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; an empty frame goes straight to the done pulse.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = (w_n_clamped == '0) ? FIN : RUN;
            end
            RUN: begin
                if (w_pop && w_last_beat) w_state_next = FIN;
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Frame counters, read address and status flags.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_n        <= '0;
            r_iss      <= '0;
            r_beat     <= '0;
            r_raddr    <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy     <= (w_state_next == RUN);
            r_done     <= (w_state_next == FIN);
            r_inflight <= w_issue;
            if (w_start_ok) begin
                r_n    <= w_n_clamped;
                r_iss  <= '0;
                r_beat <= '0;
                if (w_n_clamped != '0) r_raddr <= '0;
            end else begin
                if (w_issue) begin
                    r_iss <= r_iss + NW'(1);
                    // Hold on the last address instead of stepping past the frame.
                    if (r_iss + NW'(1) < r_n) r_raddr <= AW'(r_iss + NW'(1));
                end
                if (w_pop) r_beat <= r_beat + NW'(1);
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_raddr = r_raddr;
    assign m_valid   = w_valid;
    assign m_last    = w_valid && w_last_beat;

endmodule

// File: tb/tb_img_out_streamer.sv
// Self-checking bench for img_out_streamer against a queue-based frame model.
module tb_img_out_streamer;

    localparam int unsigned AW    = 12;
    localparam int unsigned PIX_W = 8;
    localparam int          DEPTH = 1 << AW;

    logic             clk_50 = 1'b0;
    logic             rst;
    logic             start;
    logic [AW:0]      num_pix;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_raddr;
    logic [PIX_W-1:0] mem_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_data;
    logic             m_last;

    logic [PIX_W-1:0] mem [DEPTH];

    always #10 clk_50 = ~clk_50;

    // Synchronous BRAM read, one cycle of latency.
    always @(posedge clk_50) mem_rdata <= mem[mem_raddr];

    img_out_streamer #(.AW(AW), .PIX_W(PIX_W)) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .start     (start),
        .num_pix   (num_pix),
        .busy      (busy),
        .done      (done),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Results gathered by run_frame.
    int q_data[$];
    int q_last[$];
    int beats, done_count, done_cyc, first_valid, last_beat_cyc;
    int stable_err, credit_err, wrap_err, max_raddr;
    bit busy_at_done, raddr_moved, timed_out;

    // Number of deviations of the captured stream from mem[0..n_exp-1].
    function automatic int stream_errors(input int n_exp);
        int errs = 0;
        if (q_data.size() != n_exp) errs++;
        for (int k = 0; k < n_exp && k < q_data.size(); k++)
            if (q_data[k] != int'(mem[k])) errs++;
        return errs;
    endfunction

    function automatic int last_index();
        return (q_last.size() == 1) ? q_last[0] : -1;
    endfunction

    // Start a frame and observe it cycle by cycle at the falling edge.
    // ready_mode: 0 always ready, 1 alternate 1/0, 2 random.
    task automatic run_frame(input int n_req, input int ready_mode, input int restart_at,
                             input int stop_at, input int budget);
        int cyc, prev_raddr, raddr0;
        bit prev_stall, restarted;
        logic [PIX_W-1:0] prev_data;
        logic prev_last;
        q_data.delete(); q_last.delete();
        beats = 0; done_count = 0; done_cyc = -1; first_valid = -1; last_beat_cyc = -1;
        stable_err = 0; credit_err = 0; wrap_err = 0; max_raddr = -1;
        busy_at_done = 1'b1; raddr_moved = 1'b0; timed_out = 1'b0;
        prev_raddr = 0; prev_stall = 1'b0; restarted = 1'b0; prev_data = '0; prev_last = 1'b0;
        @(negedge clk_50);
        raddr0  = int'(mem_raddr);
        start   = 1'b1;
        num_pix = (AW + 1)'(n_req);
        cyc     = 0;
        while (1) begin
            @(negedge clk_50);
            cyc++;
            start = 1'b0;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stable_err++;
            if (m_last && !m_valid) stable_err++;
            if (int'(mem_raddr) != raddr0) raddr_moved = 1'b1;
            if (busy) begin
                if (int'(mem_raddr) - beats > 2) credit_err++;
                if (int'(mem_raddr) < prev_raddr) wrap_err++;
                prev_raddr = int'(mem_raddr);
                if (int'(mem_raddr) > max_raddr) max_raddr = int'(mem_raddr);
            end
            if (done === 1'b1) begin
                done_count++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
            end
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2) == 1;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (restart_at >= 0 && !restarted && beats == restart_at) begin
                start     = 1'b1;
                num_pix   = (AW + 1)'(3);
                restarted = 1'b1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                q_data.push_back(int'(m_data));
                if (m_last) begin
                    q_last.push_back(beats);
                    last_beat_cyc = cyc;
                end
                beats++;
            end
            if (stop_at >= 0 && beats >= stop_at) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_50);
        n_checks++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", busy);       else n_pass++;
        n_checks++; if (done !== 1'b0)    $display("FAIL reset_done: got %b want 0", done);       else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid);   else n_pass++;
        n_checks++; if (m_last !== 1'b0)  $display("FAIL reset_last: got %b want 0", m_last);     else n_pass++;
        n_checks++; if (m_data !== '0)    $display("FAIL reset_data: got %h want 0", m_data);     else n_pass++;
        n_checks++; if (mem_raddr !== '0) $display("FAIL reset_raddr: got %h want 0", mem_raddr); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk_50);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_full_ready();
        run_frame(16, 0, -1, -1, 200);
        n_checks++; if (timed_out)             $display("FAIL full_timeout: got 1 want 0"); else n_pass++;
        n_checks++; if (first_valid !== 3)     $display("FAIL full_first_valid: got %0d want 3", first_valid); else n_pass++;
        n_checks++; if (stream_errors(16) !== 0) $display("FAIL full_data: got %0d errors want 0", stream_errors(16)); else n_pass++;
        n_checks++; if (last_index() !== 15)   $display("FAIL full_last: got %0d want 15", last_index()); else n_pass++;
        n_checks++; if (last_beat_cyc - first_valid !== 15) $display("FAIL full_no_bubble: got %0d want 15", last_beat_cyc - first_valid); else n_pass++;
        n_checks++; if (done_cyc !== last_beat_cyc + 1) $display("FAIL full_done_time: got %0d want %0d", done_cyc, last_beat_cyc + 1); else n_pass++;
        n_checks++; if (done_count !== 1)      $display("FAIL full_done_count: got %0d want 1", done_count); else n_pass++;
        n_checks++; if (busy_at_done !== 1'b0) $display("FAIL full_busy_at_done: got %b want 0", busy_at_done); else n_pass++;
        n_checks++; if (max_raddr !== 15)      $display("FAIL full_max_raddr: got %0d want 15", max_raddr); else n_pass++;
    endtask

    task automatic test_zero_frame();
        run_frame(0, 0, -1, -1, 50);
        n_checks++; if (done_cyc !== 1)        $display("FAIL zero_done_time: got %0d want 1", done_cyc); else n_pass++;
        n_checks++; if (done_count !== 1)      $display("FAIL zero_done_count: got %0d want 1", done_count); else n_pass++;
        n_checks++; if (first_valid !== -1)    $display("FAIL zero_valid: got %0d want -1", first_valid); else n_pass++;
        n_checks++; if (raddr_moved !== 1'b0)  $display("FAIL zero_raddr_moved: got %b want 0", raddr_moved); else n_pass++;
    endtask

    task automatic test_backpressure();
        run_frame(16, 1, -1, -1, 300);
        n_checks++; if (stream_errors(16) !== 0) $display("FAIL bp_data: got %0d errors want 0", stream_errors(16)); else n_pass++;
        n_checks++; if (stable_err !== 0)      $display("FAIL bp_stable: got %0d want 0", stable_err); else n_pass++;
        n_checks++; if (credit_err !== 0)      $display("FAIL bp_credit: got %0d want 0", credit_err); else n_pass++;
        n_checks++; if (last_index() !== 15)   $display("FAIL bp_last: got %0d want 15", last_index()); else n_pass++;
        n_checks++; if (done_count !== 1)      $display("FAIL bp_done_count: got %0d want 1", done_count); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        run_frame(16, 0, 5, -1, 200);
        n_checks++; if (beats !== 16)          $display("FAIL restart_beats: got %0d want 16", beats); else n_pass++;
        n_checks++; if (stream_errors(16) !== 0) $display("FAIL restart_data: got %0d errors want 0", stream_errors(16)); else n_pass++;
        n_checks++; if (done_count !== 1)      $display("FAIL restart_done_count: got %0d want 1", done_count); else n_pass++;
        n_checks++; if (last_index() !== 15)   $display("FAIL restart_last: got %0d want 15", last_index()); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        run_frame(16, 0, -1, 6, 200);
        @(posedge clk_50);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0)    $display("FAIL rstmid_busy: got %b want 0", busy);    else n_pass++;
        n_checks++; if (done !== 1'b0)    $display("FAIL rstmid_done: got %b want 0", done);    else n_pass++;
        @(negedge clk_50);
        rst = 1'b0;
        run_frame(8, 0, -1, -1, 200);
        n_checks++; if (stream_errors(8) !== 0) $display("FAIL rstmid_data: got %0d errors want 0", stream_errors(8)); else n_pass++;
        n_checks++; if (last_index() !== 7)  $display("FAIL rstmid_last: got %0d want 7", last_index()); else n_pass++;
        n_checks++; if (done_count !== 1)    $display("FAIL rstmid_done_count: got %0d want 1", done_count); else n_pass++;
    endtask

    task automatic test_full_frame();
        int reqs[2] = '{4096, 5000};
        foreach (reqs[r]) begin
            run_frame(reqs[r], 0, -1, -1, 5000);
            n_checks++; if (beats !== DEPTH)        $display("FAIL big%0d_beats: got %0d want %0d", r, beats, DEPTH); else n_pass++;
            n_checks++; if (stream_errors(DEPTH) !== 0) $display("FAIL big%0d_data: got %0d errors want 0", r, stream_errors(DEPTH)); else n_pass++;
            n_checks++; if (max_raddr !== DEPTH - 1) $display("FAIL big%0d_max_raddr: got %0d want %0d", r, max_raddr, DEPTH - 1); else n_pass++;
            n_checks++; if (wrap_err !== 0)          $display("FAIL big%0d_wrap: got %0d want 0", r, wrap_err); else n_pass++;
            n_checks++; if (last_index() !== DEPTH - 1) $display("FAIL big%0d_last: got %0d want %0d", r, last_index(), DEPTH - 1); else n_pass++;
            n_checks++; if (q_data.size() == 0 || q_data[q_data.size() - 1] !== 255)
                $display("FAIL big%0d_last_data: got %0d want 255", r, (q_data.size() == 0) ? -1 : q_data[q_data.size() - 1]);
            else n_pass++;
            n_checks++; if (done_count !== 1)        $display("FAIL big%0d_done_count: got %0d want 1", r, done_count); else n_pass++;
        end
    endtask

    task automatic test_random_frames();
        int n;
        for (int i = 0; i < 64; i++) mem[i] = PIX_W'($urandom);
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 40);
            run_frame(n, 2, -1, -1, 600);
            n_checks++; if (stream_errors(n) !== 0) $display("FAIL rnd%0d_data: got %0d errors want 0 (n=%0d)", f, stream_errors(n), n); else n_pass++;
            n_checks++; if (last_index() !== n - 1) $display("FAIL rnd%0d_last: got %0d want %0d", f, last_index(), n - 1); else n_pass++;
            n_checks++; if (stable_err !== 0)       $display("FAIL rnd%0d_stable: got %0d want 0", f, stable_err); else n_pass++;
            n_checks++; if (credit_err !== 0)       $display("FAIL rnd%0d_credit: got %0d want 0", f, credit_err); else n_pass++;
            n_checks++; if (done_count !== 1)       $display("FAIL rnd%0d_done_count: got %0d want 1", f, done_count); else n_pass++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        num_pix = '0;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = PIX_W'(i & 8'hFF);
        test_reset();
        test_full_ready();
        test_zero_frame();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_frame();
        test_full_frame();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
